// File: rtl/sayeh_uart_tx_port_pkg.sv
// Shared definitions for the SAYEH UART transmit port.
// Covers port addresses, transmitter states and status word layout.
package sayeh_uart_tx_port_pkg;

    localparam logic [7:0] DEF_TX_ADDR   = 8'd2;
    localparam logic [7:0] DEF_STAT_ADDR = 8'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_OVERFLOW = 3;

    // Packs the flags into the 16-bit word presented on the IO_datain mux.
    function automatic logic [15:0] make_status(
        input logic overflow,
        input logic full,
        input logic empty,
        input logic busy
    );
        logic [15:0] word;
        word                = 16'd0;
        word[STAT_OVERFLOW] = overflow;
        word[STAT_FULL]     = full;
        word[STAT_EMPTY]    = empty;
        word[STAT_BUSY]     = busy;
        return word;
    endfunction

endpackage

// File: rtl/sayeh_sync_fifo.sv
// Single-clock byte FIFO with first-word fall-through read data.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module sayeh_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sayeh_uart_tx_port.sv
// SAYEH I/O-bus UART transmitter: queues bytes written to TX_ADDR and sends them 8N1 on tx.
// Flags are readable at STAT_ADDR; overflow is sticky until that read.
module sayeh_uart_tx_port
    import sayeh_uart_tx_port_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 43,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [7:0] STAT_ADDR    = DEF_STAT_ADDR
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        WriteIO,
    input  logic        ReadIO,
    input  logic [7:0]  portadress,
    input  logic [15:0] aluout,
    output logic [15:0] IO_status,
    output logic        tx,
    output logic        busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t       state;
    logic [BW-1:0]   baudcnt;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            overflow;

    logic            push_req;
    logic            stat_read;
    logic            pop;
    logic            overflow_evt;
    logic            bit_end;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_unused;
    logic            aluout_hi_unused;

    assign push_req         = WriteIO && (portadress == TX_ADDR);
    assign stat_read        = ReadIO && (portadress == STAT_ADDR);
    assign pop              = (state == IDLE) && !fifo_empty;
    assign overflow_evt     = push_req && fifo_full && !pop;
    assign bit_end          = (baudcnt == BAUD_LAST);
    assign aluout_hi_unused = ^aluout[15:8];

    sayeh_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (push_req),
        .pop   (pop),
        .din   (aluout[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // Frame sequencer; the line is driven straight from this register, so tx never glitches.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            shreg   <= 8'd0;
            bitcnt  <= 3'd0;
            baudcnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg   <= fifo_dout;
                        tx      <= 1'b0;
                        bitcnt  <= 3'd0;
                        baudcnt <= '0;
                        busy    <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baudcnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        baudcnt <= baudcnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baudcnt <= '0;
                        if (bitcnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shreg  <= shreg >> 1;
                            tx     <= shreg[1];
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else begin
                        baudcnt <= baudcnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baudcnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        baudcnt <= baudcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Status is only non-zero in the cycle after a status read, so it can be OR-ed into IO_datain.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            overflow  <= 1'b0;
            IO_status <= 16'd0;
        end else if (stat_read) begin
            IO_status <= make_status(overflow, fifo_full, fifo_empty, busy);
            overflow  <= overflow_evt;
        end else begin
            IO_status <= 16'd0;
            if (overflow_evt) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sayeh_uart_tx_port.sv
// Directed bench for sayeh_uart_tx_port with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_sayeh_uart_tx_port;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        WriteIO;
    logic        ReadIO;
    logic [7:0]  portadress;
    logic [15:0] aluout;
    logic [15:0] IO_status;
    logic        tx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sayeh_uart_tx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .TX_ADDR      (8'd2),
        .STAT_ADDR    (8'd4)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .WriteIO    (WriteIO),
        .ReadIO     (ReadIO),
        .portadress (portadress),
        .aluout     (aluout),
        .IO_status  (IO_status),
        .tx         (tx),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one bus access that is sampled on the next rising edge.
    task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr, input logic [15:0] data);
        WriteIO    = we;
        ReadIO     = re;
        portadress = addr;
        aluout     = data;
        tick();
        WriteIO    = 1'b0;
        ReadIO     = 1'b0;
    endtask

    task automatic waitFall(input int limit, output int at, output bit found);
        bit seen_high;
        seen_high = (tx == 1'b1);
        found     = 1'b0;
        at        = 0;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (seen_high && tx == 1'b0) begin
                at    = cyc;
                found = 1'b1;
                return;
            end
            if (tx == 1'b1) seen_high = 1'b1;
        end
    endtask

    // Called right after the start-bit fall; samples each bit mid-way.
    task automatic captureFrame(output logic [7:0] data, output logic stop_bit);
        repeat (6) tick();
        for (int b = 0; b < 8; b++) begin
            data[b] = tx;
            if (b < 7) repeat (CPB) tick();
        end
        repeat (CPB) tick();
        stop_bit = tx;
    endtask

    initial begin
        logic        line [10];
        logic [7:0]  queued [4];
        logic [7:0]  got;
        logic        stop_bit;
        int          at;
        int          prev;
        bit          found;

        line   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        queued = '{8'h11, 8'h22, 8'h3C, 8'hC3};

        Reset = 1'b1; WriteIO = 1'b0; ReadIO = 1'b0; portadress = 8'd0; aluout = 16'd0;
        #3;
        checkOutput("reset_tx", {15'd0, tx}, 16'd1);
        checkOutput("reset_busy", {15'd0, busy}, 16'd0);
        checkOutput("reset_status", IO_status, 16'd0);
        tick(); tick();
        Reset = 1'b0;
        tick();

        // Single frame of 8'hA5, checked cycle by cycle.
        applyStimulus(1'b1, 1'b0, 8'd2, 16'hFFA5);
        checkOutput("a5_tx_before_start", {15'd0, tx}, 16'd1);
        tick();
        for (int c = 0; c < 10*CPB; c++) begin
            checkOutput($sformatf("a5_line_c%0d", c), {14'd0, busy, tx}, {14'd0, 1'b1, line[c/CPB]});
            tick();
        end
        checkOutput("a5_after_frame", {14'd0, busy, tx}, 16'd1);

        // Other addresses have no effect.
        repeat (3) tick();
        applyStimulus(1'b1, 1'b0, 8'd3, 16'h0055);
        checkOutput("port3_write_status", IO_status, 16'd0);
        applyStimulus(1'b0, 1'b1, 8'd2, 16'd0);
        checkOutput("port2_read_status", IO_status, 16'd0);
        waitFall(10, at, found);
        checkOutput("port3_no_frame", {15'd0, found}, 16'd0);
        applyStimulus(1'b0, 1'b1, 8'd4, 16'd0);
        checkOutput("idle_status", IO_status, 16'h0002);
        tick();
        checkOutput("status_returns_zero", IO_status, 16'd0);

        // Six back-to-back writes: one popped, four queued, one dropped.
        applyStimulus(1'b1, 1'b0, 8'd2, 16'h00E7);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'd2, {8'h00, queued[i]});
        applyStimulus(1'b1, 1'b0, 8'd2, 16'h0099);
        repeat (36) tick();
        applyStimulus(1'b0, 1'b1, 8'd4, 16'd0);
        checkOutput("ovf_full_status", IO_status, 16'h000C);
        checkOutput("frame2_started", {15'd0, tx}, 16'd0);
        prev = cyc;
        captureFrame(got, stop_bit);
        checkOutput("frame2_data", {8'd0, got}, {8'd0, queued[0]});
        checkOutput("frame2_stop", {15'd0, stop_bit}, 16'd1);
        for (int j = 1; j < 4; j++) begin
            waitFall(200, at, found);
            checkOutput($sformatf("frame%0d_found", j+2), {15'd0, found}, 16'd1);
            checkOutput($sformatf("frame%0d_spacing", j+2), 16'(at - prev), 16'(10*CPB + 1));
            prev = at;
            captureFrame(got, stop_bit);
            checkOutput($sformatf("frame%0d_data", j+2), {8'd0, got}, {8'd0, queued[j]});
            checkOutput($sformatf("frame%0d_stop", j+2), {15'd0, stop_bit}, 16'd1);
        end
        waitFall(60, at, found);
        checkOutput("dropped_byte_not_sent", {15'd0, found}, 16'd0);
        applyStimulus(1'b0, 1'b1, 8'd4, 16'd0);
        checkOutput("ovf_cleared_status", IO_status, 16'h0002);

        // Asynchronous reset during a start bit with a byte still queued.
        tick();
        applyStimulus(1'b1, 1'b0, 8'd2, 16'h0033);
        applyStimulus(1'b1, 1'b0, 8'd2, 16'h0044);
        applyStimulus(1'b0, 1'b1, 8'd4, 16'd0);
        checkOutput("busy_status", IO_status, 16'h0001);
        checkOutput("start_bit_low", {15'd0, tx}, 16'd0);
        #2 Reset = 1'b1;
        #1;
        checkOutput("async_reset_tx", {15'd0, tx}, 16'd1);
        checkOutput("async_reset_busy", {15'd0, busy}, 16'd0);
        checkOutput("async_reset_status", IO_status, 16'd0);
        tick();
        Reset = 1'b0;
        waitFall(60, at, found);
        checkOutput("no_frame_after_reset", {15'd0, found}, 16'd0);
        applyStimulus(1'b0, 1'b1, 8'd4, 16'd0);
        checkOutput("empty_after_reset", IO_status, 16'h0002);

        // Asynchronous reset during data bit 3 of 8'hF0 (bit 3 is 0).
        tick();
        applyStimulus(1'b1, 1'b0, 8'd2, 16'h00F0);
        applyStimulus(1'b1, 1'b0, 8'd2, 16'h0077);
        repeat (17) tick();
        checkOutput("data_bit3_low", {14'd0, busy, tx}, 16'h0002);
        #2 Reset = 1'b1;
        #1;
        checkOutput("bit3_reset_tx", {14'd0, busy, tx}, 16'h0001);
        tick();
        Reset = 1'b0;
        waitFall(60, at, found);
        checkOutput("bit3_no_frame_after", {15'd0, found}, 16'd0);
        applyStimulus(1'b0, 1'b1, 8'd4, 16'd0);
        checkOutput("bit3_empty_idle", IO_status, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
